// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, honours
// stall/flush/redirect from the hazard unit, and keeps stall/flush statistics.
module if_id_fetch_stage #(
    parameter int                      PC_WIDTH    = 32,
    parameter int                      INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0000,
    parameter int                      STALL_LIMIT = 64,
    parameter int                      CNT_WIDTH   = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ID_Stall,
    input  logic                   Flush_IF_ID,
    input  logic                   Branch_Taken,
    input  logic [PC_WIDTH-1:0]    Branch_Target,
    output logic [PC_WIDTH-1:0]    IMem_Addr,
    input  logic [INSTR_WIDTH-1:0] IMem_Instr,
    output logic [INSTR_WIDTH-1:0] IF_ID_Instr,
    output logic [PC_WIDTH-1:0]    IF_ID_PCPlus4,
    output logic                   IF_ID_Valid,
    output logic [CNT_WIDTH-1:0]   Stall_Count,
    output logic [CNT_WIDTH-1:0]   Flush_Count,
    output logic                   Stall_Timeout
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_plus4;
    logic [RUN_W-1:0]    stall_run;
    logic                active, do_branch, do_stall, do_flush, do_fetch;

    assign IMem_Addr = pc;
    assign pc_plus4  = pc + PC_WIDTH'(4);

    // Redirect beats stall beats flush; nothing acts during the BOOT edge.
    assign active    = (state != BOOT);
    assign do_branch = active &  Branch_Taken;
    assign do_stall  = active & ~Branch_Taken &  ID_Stall;
    assign do_flush  = active & ~Branch_Taken & ~ID_Stall &  Flush_IF_ID;
    assign do_fetch  = active & ~Branch_Taken & ~ID_Stall & ~Flush_IF_ID;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (ID_Stall && !Branch_Taken) state_nxt = HOLD;
            HOLD:    if (!ID_Stall || Branch_Taken) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCPlus4 <= '0;
            IF_ID_Valid   <= 1'b0;
            Stall_Count   <= '0;
            Flush_Count   <= '0;
            Stall_Timeout <= 1'b0;
            stall_run     <= '0;
        end else begin
            state <= state_nxt;

            if (do_branch) begin
                pc          <= Branch_Target;
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end else if (do_flush) begin
                pc          <= pc_plus4;
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end else if (do_fetch) begin
                pc            <= pc_plus4;
                IF_ID_Instr   <= IMem_Instr;
                IF_ID_PCPlus4 <= pc_plus4;
                IF_ID_Valid   <= 1'b1;
            end

            if ((do_branch || do_flush) && Flush_Count != '1)
                Flush_Count <= Flush_Count + 1'b1;
            if (do_stall && Stall_Count != '1)
                Stall_Count <= Stall_Count + 1'b1;

            // Run counter parks at STALL_LIMIT; the timeout is sticky until reset.
            if (do_stall) begin
                if (stall_run != RUN_W'(STALL_LIMIT))
                    stall_run <= stall_run + 1'b1;
                if (stall_run >= RUN_W'(STALL_LIMIT - 1))
                    Stall_Timeout <= 1'b1;
            end else if (active) begin
                stall_run <= '0;
            end
        end
    end

endmodule
